// File: rtl/dmem_bridge.sv
// dmem_bridge: connects the M-stage load/store port to a split address/data
// handshake bus. Decodes MIPS load/store opcodes, checks alignment, formats
// store lanes, extends load data and holds the pipeline while the bus works.
module dmem_bridge #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic [5:0]  opM,
  input  logic [31:0] addrM,
  input  logic [31:0] wdataM,
  output logic [31:0] rdataM,
  output logic        stall_mem,
  output logic        adel,
  output logic        ades,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          bus_err_q, bus_err_d;
  logic [5:0]    op_q, op_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;

  function automatic logic op_known(input logic [5:0] op);
    return op inside {6'h20, 6'h24, 6'h21, 6'h25, 6'h23, 6'h28, 6'h29, 6'h2B};
  endfunction

  function automatic logic op_store(input logic [5:0] op);
    return op inside {6'h28, 6'h29, 6'h2B};
  endfunction

  function automatic logic op_sext(input logic [5:0] op);
    return op inside {6'h20, 6'h21};
  endfunction

  // 0 = byte, 1 = half, 2 = word
  function automatic logic [1:0] op_size(input logic [5:0] op);
    case (op)
      6'h20, 6'h24, 6'h28: return 2'd0;
      6'h21, 6'h25, 6'h29: return 2'd1;
      default:             return 2'd2;
    endcase
  endfunction

  logic        cur_known, cur_store, cur_mis, acc_ok;
  logic [1:0]  cur_size;
  logic [5:0]  sel_op;
  logic [31:0] sel_addr, sel_wdata;
  logic        sel_store, sel_sext;
  logic [1:0]  sel_size;
  logic [3:0]  wstrb_fmt;
  logic [31:0] wdata_fmt, load_ext;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        req_on;

  // Decode and alignment check of the live M-stage request
  always_comb begin
    cur_known = mem_en & op_known(opM);
    cur_store = op_store(opM);
    cur_size  = op_size(opM);
    cur_mis   = cur_known & (((cur_size == 2'd1) & addrM[0]) |
                             ((cur_size == 2'd2) & (addrM[1:0] != 2'b00)));
    acc_ok    = cur_known & ~cur_mis;
    adel      = cur_mis & ~cur_store;
    ades      = cur_mis & cur_store;
  end

  // Bus formatting: live inputs while idle, latched request once the bus owns it
  always_comb begin
    sel_op    = (state_q == IDLE) ? opM    : op_q;
    sel_addr  = (state_q == IDLE) ? addrM  : addr_q;
    sel_wdata = (state_q == IDLE) ? wdataM : wdata_q;
    sel_store = op_store(sel_op);
    sel_sext  = op_sext(sel_op);
    sel_size  = op_size(sel_op);

    case (sel_size)
      2'd0: begin
        wstrb_fmt = 4'b0001 << sel_addr[1:0];
        wdata_fmt = {4{sel_wdata[7:0]}};
      end
      2'd1: begin
        wstrb_fmt = sel_addr[1] ? 4'b1100 : 4'b0011;
        wdata_fmt = {2{sel_wdata[15:0]}};
      end
      default: begin
        wstrb_fmt = 4'b1111;
        wdata_fmt = sel_wdata;
      end
    endcase
    if (!sel_store) wstrb_fmt = '0;

    case (sel_addr[1:0])
      2'd0:    ld_byte = bus_rdata[7:0];
      2'd1:    ld_byte = bus_rdata[15:8];
      2'd2:    ld_byte = bus_rdata[23:16];
      default: ld_byte = bus_rdata[31:24];
    endcase
    ld_half = sel_addr[1] ? bus_rdata[31:16] : bus_rdata[15:0];

    case (sel_size)
      2'd0:    load_ext = {{24{sel_sext & ld_byte[7]}}, ld_byte};
      2'd1:    load_ext = {{16{sel_sext & ld_half[15]}}, ld_half};
      default: load_ext = bus_rdata;
    endcase
  end

  // Output drive; reset forces the handshake and stall quiet
  always_comb begin
    req_on    = rst & (((state_q == IDLE) & acc_ok) | (state_q == ADDR));
    bus_req   = req_on;
    bus_wr    = req_on & sel_store;
    bus_wstrb = req_on ? wstrb_fmt : '0;
    bus_size  = sel_size;
    bus_addr  = {sel_addr[31:2], 2'b00};
    bus_wdata = wdata_fmt;
    stall_mem = rst & ((state_q == IDLE) ? acc_ok : (state_q != DONE));
    rdataM    = rdata_q;
    bus_err   = bus_err_q;
  end

  // Next-state logic: request latch, data capture and DATA-phase timeout
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    rdata_d   = rdata_q;
    bus_err_d = 1'b0;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    case (state_q)
      IDLE: begin
        if (acc_ok) begin
          op_d    = opM;
          addr_d  = addrM;
          wdata_d = wdataM;
          state_d = bus_addr_ok ? DATA : ADDR;
        end
      end
      ADDR: begin
        if (bus_addr_ok) state_d = DATA;
      end
      DATA: begin
        // data_ok wins over a timeout landing in the same cycle
        if (bus_data_ok) begin
          if (!sel_store) rdata_d = load_ext;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          bus_err_d = 1'b1;
          rdata_d   = '0;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and data registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rdata_q   <= '0;
      bus_err_q <= 1'b0;
      op_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      bus_err_q <= bus_err_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: randomized and directed load/store traffic against a
// transaction-level model of the bridge, with a scripted bus responder.
module tb_dmem_bridge;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en;
  logic [5:0]  opM;
  logic [31:0] addrM, wdataM, rdataM;
  logic        stall_mem, adel, ades, bus_err;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] bus_rdata;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] exp_rd   = '0;

  always #5 clk = ~clk;

  dmem_bridge #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .mem_en(mem_en), .opM(opM), .addrM(addrM),
    .wdataM(wdataM), .rdataM(rdataM), .stall_mem(stall_mem), .adel(adel),
    .ades(ades), .bus_err(bus_err), .bus_req(bus_req), .bus_wr(bus_wr),
    .bus_size(bus_size), .bus_wstrb(bus_wstrb), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
    .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One M-stage access. ad = cycles without addr_ok before the accepting
  // cycle; dd = DATA cycles without data_ok before it arrives (>= TO means
  // it never arrives).
  task automatic access(input logic en, input logic [5:0] op,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int unsigned ad,
                        input int unsigned dd, input bit scramble);
    bit known, ld, sx, mis, go, tmo;
    int unsigned sz, total;
    logic [31:0] b, h, lv, ewstrb, ewdata, old_rd;
    known = 1'b1; ld = 1'b1; sx = 1'b0; sz = 2;
    case (op)
      6'h20: begin sx = 1'b1; sz = 0; end
      6'h24: sz = 0;
      6'h21: begin sx = 1'b1; sz = 1; end
      6'h25: sz = 1;
      6'h23: sz = 2;
      6'h28: begin ld = 1'b0; sz = 0; end
      6'h29: begin ld = 1'b0; sz = 1; end
      6'h2B: begin ld = 1'b0; sz = 2; end
      default: known = 1'b0;
    endcase
    known = known && en;
    mis = known && ((sz == 1 && addr[0]) || (sz == 2 && addr[1:0] != 2'b00));
    go  = known && !mis;

    b = (rdata >> (8 * addr[1:0])) & 32'hFF;
    h = (rdata >> (16 * addr[1])) & 32'hFFFF;
    if (sz == 0)      lv = (sx && b[7])  ? (b | 32'hFFFF_FF00) : b;
    else if (sz == 1) lv = (sx && h[15]) ? (h | 32'hFFFF_0000) : h;
    else              lv = rdata;
    if (ld)           ewstrb = 0;
    else if (sz == 0) ewstrb = 32'd1 << addr[1:0];
    else if (sz == 1) ewstrb = 32'd3 << addr[1:0];
    else              ewstrb = 32'd15;
    if (sz == 0)      ewdata = (wdata & 32'hFF) * 32'h0101_0101;
    else if (sz == 1) ewdata = (wdata & 32'hFFFF) * 32'h0001_0001;
    else              ewdata = wdata;

    mem_en = en; opM = op; addrM = addr; wdataM = wdata; bus_rdata = rdata;

    if (!go) begin
      bus_addr_ok = 1'($urandom_range(0, 1));
      bus_data_ok = 1'($urandom_range(0, 1));
      #3;
      check_eq("nop_stall", 32'(stall_mem), 0);
      check_eq("nop_req", 32'(bus_req), 0);
      check_eq("nop_wstrb", 32'(bus_wstrb), 0);
      check_eq("adel", 32'(adel), 32'(mis && ld));
      check_eq("ades", 32'(ades), 32'(mis && !ld));
      check_eq("nop_rdata", rdataM, exp_rd);
      step();
      return;
    end

    tmo   = (dd >= TO);
    total = ad + 1 + (tmo ? TO : dd + 1);
    old_rd = exp_rd;
    for (int unsigned c = 0; c <= total; c++) begin
      bus_addr_ok = (c == ad);
      if (c <= ad || c == total) bus_data_ok = 1'($urandom_range(0, 1));
      else                       bus_data_ok = !tmo && (c == ad + 1 + dd);
      if (scramble && c > 0) begin
        opM = 6'($urandom); addrM = $urandom; wdataM = $urandom;
      end
      #3;
      if (c == 0) begin
        check_eq("adel0", 32'(adel), 0);
        check_eq("ades0", 32'(ades), 0);
      end
      check_eq("stall", 32'(stall_mem), 32'(c < total));
      check_eq("req", 32'(bus_req), 32'(c <= ad));
      if (c <= ad) begin
        check_eq("baddr", bus_addr, {addr[31:2], 2'b00});
        check_eq("bsize", 32'(bus_size), sz);
        check_eq("bwr", 32'(bus_wr), 32'(!ld));
        check_eq("bwstrb", 32'(bus_wstrb), ewstrb);
        if (!ld) check_eq("bwdata", bus_wdata, ewdata);
      end
      check_eq("berr", 32'(bus_err), 32'(tmo && c == total));
      if (c == total) begin
        if (tmo)     exp_rd = 0;
        else if (ld) exp_rd = lv;
        check_eq("rdata_done", rdataM, exp_rd);
      end else begin
        check_eq("rdata_hold", rdataM, old_rd);
      end
      step();
    end
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
  endtask

  localparam logic [5:0] OPS [10] = '{6'h20, 6'h24, 6'h21, 6'h25, 6'h23,
                                      6'h28, 6'h29, 6'h2B, 6'h00, 6'h22};

  initial begin
    rst = 1'b0; mem_en = 1'b1; opM = 6'h23; addrM = 32'h100; wdataM = '0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
    @(posedge clk); #1;
    #3;
    check_eq("rst_stall", 32'(stall_mem), 0);
    check_eq("rst_req", 32'(bus_req), 0);
    check_eq("rst_wstrb", 32'(bus_wstrb), 0);
    check_eq("rst_rdata", rdataM, 0);
    check_eq("rst_berr", 32'(bus_err), 0);
    step();
    rst = 1'b1; mem_en = 1'b0;
    step();

    // lw 0x100, addr_ok at once, data_ok next cycle
    access(1'b1, 6'h23, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 1'b0);
    check_eq("lw_const", rdataM, 32'hDEADBEEF);
    // lb / lbu of the top byte
    access(1'b1, 6'h20, 32'h103, 32'h0, 32'h80FF7F01, 0, 0, 1'b0);
    check_eq("lb_const", rdataM, 32'hFFFFFF80);
    access(1'b1, 6'h24, 32'h103, 32'h0, 32'h80FF7F01, 1, 1, 1'b0);
    check_eq("lbu_const", rdataM, 32'h00000080);
    // sh upper half: fixed-value lane checks on the request cycle
    mem_en = 1'b1; opM = 6'h29; addrM = 32'h202; wdataM = 32'h1234ABCD;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    #3;
    check_eq("sh_wdata", bus_wdata, 32'hABCDABCD);
    check_eq("sh_wstrb", 32'(bus_wstrb), 32'hC);
    check_eq("sh_wr", 32'(bus_wr), 1);
    check_eq("sh_addr", bus_addr, 32'h200);
    #1;
    mem_en = 1'b0;
    access(1'b1, 6'h29, 32'h202, 32'h1234ABCD, 32'h0, 0, 0, 1'b0);
    // misaligned
    access(1'b1, 6'h23, 32'h102, 32'h0, 32'h0, 0, 0, 1'b0);
    access(1'b1, 6'h29, 32'h201, 32'h0, 32'h0, 0, 0, 1'b0);
    // addr_ok held off 3 cycles with inputs churning: 5 stall cycles
    access(1'b1, 6'h2B, 32'h300, 32'hCAFEF00D, 32'h0, 3, 0, 1'b1);
    // data_ok never arrives
    access(1'b1, 6'h23, 32'h104, 32'h0, 32'h11112222, 0, TO + 2, 1'b0);
    // data_ok on the last DATA cycle before the timeout
    access(1'b1, 6'h21, 32'h106, 32'h0, 32'h9234_5678, 2, TO - 1, 1'b0);

    // reset while in DATA
    access(1'b1, 6'h23, 32'h108, 32'h0, 32'h5A5A1234, 0, 0, 1'b0);
    mem_en = 1'b1; opM = 6'h23; addrM = 32'h10C; bus_addr_ok = 1'b1;
    bus_data_ok = 1'b0;
    #3;
    check_eq("mr_req", 32'(bus_req), 1);
    step();
    bus_addr_ok = 1'b0; rst = 1'b0;
    #3;
    check_eq("mr_rst_req", 32'(bus_req), 0);
    check_eq("mr_rst_stall", 32'(stall_mem), 0);
    check_eq("mr_rst_wstrb", 32'(bus_wstrb), 0);
    step();
    rst = 1'b1; mem_en = 1'b0; bus_data_ok = 1'b1;
    exp_rd = 0;
    #3;
    check_eq("mr_stall", 32'(stall_mem), 0);
    check_eq("mr_req_after", 32'(bus_req), 0);
    check_eq("mr_rdata", rdataM, 0);
    check_eq("mr_berr", 32'(bus_err), 0);
    step();
    bus_data_ok = 1'b0;
    step();
    #3;
    check_eq("mr_idle_rdata", rdataM, 0);
    step();
    access(1'b1, 6'h25, 32'h10E, 32'h0, 32'h8001_7FFE, 1, 2, 1'b0);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      logic        en;
      logic [5:0]  op;
      int unsigned ad, dd;
      en = ($urandom_range(0, 7) != 0);
      op = OPS[$urandom_range(0, 9)];
      ad = $urandom_range(0, 3);
      dd = ($urandom_range(0, 9) == 0) ? TO + $urandom_range(0, 2)
                                       : $urandom_range(0, TO - 1);
      access(en, op, $urandom, $urandom, $urandom, ad, dd,
             1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_bridge.md
DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255: maximum cycles spent waiting for bus_data_ok before the bridge aborts the access.
REQ-002 SHALL have port clk, in, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, in, 1: reset, synchronous and active-low.
REQ-004 SHALL have port mem_en, in, 1: M-stage instruction is a load or store.
REQ-005 SHALL have port opM, in, 6: M-stage opcode.
REQ-006 SHALL have port addrM, in, 32: effective address (aluoutM).
REQ-007 SHALL have port wdataM, in, 32: store data (writedataM).
REQ-008 SHALL have port rdataM, out, 32: extended load result (readdataM).
REQ-009 SHALL have port stall_mem, out, 1: pipeline hold request.
REQ-010 SHALL have ports adel and ades, out, 1 each: load/store address-error flags.
REQ-011 SHALL have port bus_err, out, 1: timeout pulse.
REQ-012 SHALL have bus outputs: bus_req 1, bus_wr 1, bus_size 2, bus_wstrb 4, bus_addr 32, bus_wdata 32.
REQ-013 SHALL have bus inputs: bus_addr_ok 1, bus_data_ok 1, bus_rdata 32.

Function
REQ-014 SHALL decode opM 0x20 lb, 0x24 lbu, 0x21 lh, 0x25 lhu, 0x23 lw, 0x28 sb, 0x29 sh, 0x2B sw; with mem_en=1, any other opcode causes no bus activity and stall_mem=0.
REQ-015 SHALL flag misalignment combinationally: halfword with addrM[0]=1, or word with addrM[1:0]!=0; adel for loads, ades for stores.
REQ-016 SHALL, when an access is misaligned, issue no bus_req and hold stall_mem=0.
REQ-017 SHALL implement the FSM states IDLE, ADDR, DATA and DONE.
REQ-018 SHALL, in IDLE with a valid aligned access, assert bus_req combinationally; on bus_addr_ok go to DATA, else go to ADDR.
REQ-019 SHALL, in ADDR, hold bus_req with stable address, data and strobes until bus_addr_ok, then go to DATA.
REQ-020 SHALL deassert bus_req in DATA and honour bus_data_ok only in DATA; on bus_data_ok, capture the extended read data into rdataM and go to DONE.
REQ-021 SHALL remain in DONE exactly one cycle, then return to IDLE.
REQ-022 SHALL drive stall_mem = valid aligned access AND state != DONE, so stall_mem is 0 throughout DONE.
REQ-023 SHALL therefore give a minimum stall of 2 cycles (addr_ok in the first cycle, data_ok in the next), with the pipeline advancing at the end of DONE.
REQ-024 SHALL set bus_addr to {addrM[31:2],2'b00} and bus_size to 0 for byte, 1 for half and 2 for word accesses.
REQ-025 SHALL set bus_wstrb for sb to 4'b0001<<addrM[1:0]; for sh to 0011 when addrM[1]=0, else 1100; for sw to 1111; for loads to 0000.
REQ-026 SHALL replicate store data on bus_wdata: sb {4{wdataM[7:0]}}, sh {2{wdataM[15:0]}}, sw wdataM.
REQ-027 SHALL select the load lane by addrM[1:0] (byte) or addrM[1] (half), sign-extending for lb/lh and zero-extending for lbu/lhu.
REQ-028 SHALL write rdataM only on capture or timeout and hold it otherwise; stores leave rdataM unchanged.
REQ-029 SHALL count cycles in DATA; on reaching TIMEOUT_CYC without data_ok, pulse bus_err for 1 cycle, load rdataM=0 and go to DONE.
REQ-030 SHALL, when bus_addr_ok and bus_data_ok arrive in the same IDLE/ADDR cycle, treat data_ok as not yet received.
REQ-031 SHALL ignore changes on opM, addrM and wdataM while in ADDR or DATA, because the latched request is used.

Reset
REQ-032 SHALL, on rst=0 at a clock edge, force state IDLE, clear the timeout counter, and zero rdataM, bus_err and the latched request.
REQ-033 SHALL, when reset occurs mid-access, abandon the transaction with no completion and issue bus_req only for new requests after release.
REQ-034 SHALL, during reset, drive bus_req=0, stall_mem=0 and bus_wstrb=0.

Verification
REQ-035 SHALL cover an lw at 0x100 with addr_ok in cycle 0 and data_ok in cycle 1 returning 0xDEADBEEF -> stall_mem=1 for 2 cycles, rdataM=0xDEADBEEF in DONE.
REQ-036 SHALL cover an lb at 0x103 and an lbu at 0x103 with bus_rdata=0x80FF7F01 -> rdataM=0xFFFFFF80 and 0x00000080 respectively.
REQ-037 SHALL cover sh of wdataM=0x1234ABCD to 0x202 -> bus_wdata=0xABCDABCD, bus_wstrb=1100, bus_wr=1, bus_addr=0x200.
REQ-038 SHALL cover lw at 0x102 and sh at 0x201 -> adel=1 and ades=1 respectively, with no bus_req and stall_mem=0.
REQ-039 SHALL cover addr_ok delayed 3 cycles with wdataM changed meanwhile -> bus signals stay stable and stall_mem lasts 5 cycles.
REQ-040 SHALL cover data_ok never arriving with TIMEOUT_CYC=4 -> bus_err pulses once, rdataM=0, and stall_mem drops the next cycle; separately, rst=0 in DATA -> IDLE with stall_mem=0.
